// File: rtl/int_arb.sv
// Platform interrupt arbiter: latches rising edges on peripheral lines, masks them with
// ENABLE, presents the highest-priority ID to the core and tracks one source in service.
module int_arb #(
  parameter int N_SRC   = 8,
  parameter int BASE_ID = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_i,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      data_i,
  output logic [31:0]      data_o,
  output logic [7:0]       int_flag_o
);

  localparam logic [1:0] A_ENABLE  = 2'd0;
  localparam logic [1:0] A_PENDING = 2'd1;
  localparam logic [1:0] A_CLAIM   = 2'd2;
  localparam logic [1:0] A_STATUS  = 2'd3;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           state_reg;
  logic [N_SRC-1:0] enable_reg;
  logic [N_SRC-1:0] pending_reg;
  logic [N_SRC-1:0] pending_next;
  logic [N_SRC-1:0] irq_q;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] win_onehot;
  logic [7:0]       active_id_reg;
  logic [7:0]       win_id;
  logic [1:0]       reg_sel;
  logic             rd_claim;
  logic             wr_claim;
  logic             wr_enable;
  logic             claim_ok;
  logic [31:0]      rd_data;
  logic             unused_bits;

  assign unused_bits = ^{addr_i[31:4], addr_i[1:0], data_i[31:8]};

  assign reg_sel   = addr_i[3:2];
  assign rd_claim  = req_i && !we_i && (reg_sel == A_CLAIM);
  assign wr_claim  = req_i &&  we_i && (reg_sel == A_CLAIM);
  assign wr_enable = req_i &&  we_i && (reg_sel == A_ENABLE);

  assign rise     = irq_i & ~irq_q;
  assign eligible = pending_reg & enable_reg;

  // One-hot of the lowest-index eligible source (index 0 wins).
  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_win
      if (gi == 0) begin : g_first
        assign win_onehot[gi] = eligible[gi];
      end else begin : g_rest
        assign win_onehot[gi] = eligible[gi] & ~|eligible[gi-1:0];
      end
    end
  endgenerate

  always_comb begin
    win_id = 8'd0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (eligible[k]) win_id = 8'(BASE_ID + k);
    end
  end

  assign claim_ok = rd_claim && (state_reg == S_IDLE) && (win_id != 8'd0);

  // A fresh rise on the source being claimed re-sets its bit: set beats clear.
  always_comb begin
    pending_next = pending_reg;
    if (claim_ok) pending_next = pending_next & ~win_onehot;
    pending_next = pending_next | rise;
  end

  always_comb begin
    rd_data = 32'd0;
    case (reg_sel)
      A_ENABLE:  rd_data[N_SRC-1:0] = enable_reg;
      A_PENDING: rd_data[N_SRC-1:0] = pending_reg;
      A_CLAIM:   rd_data[7:0]       = (state_reg == S_IDLE) ? win_id : 8'd0;
      A_STATUS: begin
        rd_data[0]    = (state_reg == S_BUSY);
        rd_data[11:4] = active_id_reg;
      end
      default:   rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      enable_reg    <= '0;
      pending_reg   <= '0;
      irq_q         <= '0;
      active_id_reg <= 8'd0;
      data_o        <= 32'd0;
      int_flag_o    <= 8'd0;
    end else begin
      irq_q       <= irq_i;
      pending_reg <= pending_next;
      if (req_i && !we_i) data_o <= rd_data;
      if (wr_enable) enable_reg <= data_i[N_SRC-1:0];

      case (state_reg)
        S_IDLE: begin
          if (claim_ok) begin
            active_id_reg <= win_id;
            int_flag_o    <= 8'd0;
            state_reg     <= S_BUSY;
          end else begin
            int_flag_o <= win_id;
          end
        end
        S_BUSY: begin
          // No nesting: the core sees nothing until the active source completes.
          int_flag_o <= 8'd0;
          if (wr_claim && (data_i[7:0] == active_id_reg)) begin
            active_id_reg <= 8'd0;
            state_reg     <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_arb.sv
// Self-checking bench for int_arb: one table row per clock cycle, expectations queued at
// drive time and compared after the edge that ends the cycle.
module tb_int_arb;

  localparam logic [31:0] EN   = 32'h0;
  localparam logic [31:0] PEND = 32'h4;
  localparam logic [31:0] CLM  = 32'h8;
  localparam logic [31:0] STAT = 32'hC;

  typedef struct {
    logic [7:0]  irq;
    bit          req;
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    bit          chk_d;
    logic [31:0] exp_d;
    logic [7:0]  exp_f;
    int          row;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_i;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic [7:0]  int_flag_o;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];
  vec_t sb[$];
  vec_t cur;

  int_arb #(.N_SRC(8), .BASE_ID(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_i      (irq_i),
    .req_i      (req_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .data_o     (data_o),
    .int_flag_o (int_flag_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic void mk(input logic [7:0] irq, input bit req, input bit we,
                             input logic [31:0] addr, input logic [31:0] data,
                             input bit chk_d, input logic [31:0] exp_d, input logic [7:0] exp_f);
    vec_t v;
    v.irq = irq; v.req = req; v.we = we; v.addr = addr; v.data = data;
    v.chk_d = chk_d; v.exp_d = exp_d; v.exp_f = exp_f; v.row = vecs.size();
    vecs.push_back(v);
  endfunction

  function automatic void idle(input logic [7:0] irq, input logic [7:0] f);
    mk(irq, 0, 0, 32'h0, 32'h0, 0, 32'h0, f);
  endfunction

  function automatic void rd(input logic [7:0] irq, input logic [31:0] a,
                             input logic [31:0] d, input logic [7:0] f);
    mk(irq, 1, 0, a, 32'h0, 1, d, f);
  endfunction

  function automatic void wr(input logic [7:0] irq, input logic [31:0] a,
                             input logic [31:0] d, input logic [7:0] f);
    mk(irq, 1, 1, a, d, 0, 32'h0, f);
  endfunction

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    irq_i = v.irq; req_i = v.req; we_i = v.we; addr_i = v.addr; data_i = v.data;
    sb.push_back(v);
    @(posedge clk);
    #1;
    cur = sb.pop_front();
    if (cur.chk_d) check($sformatf("row%0d data_o", cur.row), data_o, cur.exp_d);
    check($sformatf("row%0d int_flag_o", cur.row), {24'h0, int_flag_o}, {24'h0, cur.exp_f});
    $display("row %0d: irq=%h req=%0d we=%0d addr=%h wdata=%h -> data_o=%h int_flag_o=%0d",
             cur.row, cur.irq, cur.req, cur.we, cur.addr, cur.data, data_o, int_flag_o);
  endtask

  initial begin
    rst = 1'b1; irq_i = 8'h0; req_i = 1'b0; we_i = 1'b0; addr_i = 32'h0; data_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset data_o", data_o, 32'h0);
    check("reset int_flag_o", {24'h0, int_flag_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single source, two-cycle flag latency.
    wr(0, EN, 32'h05, 0);
    idle(8'h04, 0);
    idle(8'h00, 3);
    rd(0, PEND, 32'h04, 3);
    // Simultaneous rises, claim the winner.
    idle(8'h05, 3);
    idle(8'h00, 1);
    rd(0, CLM, 32'h1, 0);
    rd(0, PEND, 32'h04, 0);
    rd(0, STAT, 32'h11, 0);
    // Wrong complete ignored, busy claim read has no effect, right complete releases.
    wr(0, CLM, 32'h3, 0);
    rd(0, STAT, 32'h11, 0);
    rd(0, CLM, 32'h0, 0);
    rd(0, STAT, 32'h11, 0);
    wr(0, CLM, 32'h1, 0);
    idle(0, 3);
    rd(0, CLM, 32'h3, 0);
    wr(0, CLM, 32'h3, 0);
    idle(0, 0);
    // Level held 10 cycles sets pending once.
    wr(0, EN, 32'h02, 0);
    idle(8'h02, 0);
    rd(8'h02, PEND, 32'h02, 2);
    for (int i = 0; i < 8; i++) idle(8'h02, 2);
    rd(8'h02, CLM, 32'h2, 0);
    rd(8'h02, PEND, 32'h0, 0);
    rd(8'h02, CLM, 32'h0, 0);
    wr(0, CLM, 32'h2, 0);
    idle(0, 0);
    idle(8'h02, 0);
    rd(0, PEND, 32'h02, 2);
    rd(0, CLM, 32'h2, 0);
    wr(0, CLM, 32'h2, 0);
    idle(0, 0);
    // Rise coinciding with its own claim keeps pending set.
    wr(0, EN, 32'h03, 0);
    idle(8'h01, 0);
    idle(8'h00, 1);
    rd(8'h01, CLM, 32'h1, 0);
    rd(0, PEND, 32'h01, 0);
    wr(0, CLM, 32'h1, 0);
    idle(0, 1);
    // Disable while pending, aliasing, read-only PENDING, data_o hold.
    wr(0, EN, 32'h0, 1);
    idle(0, 0);
    rd(0, 32'h0000_0F04, 32'h01, 0);
    wr(0, PEND, 32'hFF, 0);
    rd(0, PEND, 32'h01, 0);
    mk(0, 0, 0, 32'h0, 32'h0, 1, 32'h01, 0);
    wr(0, EN, 32'h01, 0);
    idle(0, 1);
    // Busy with two pending, then reset.
    idle(8'h02, 1);
    rd(0, CLM, 32'h1, 0);
    idle(8'h01, 0);
    rd(0, STAT, 32'h11, 0);
    rd(0, PEND, 32'h03, 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    @(negedge clk);
    rst = 1'b1; irq_i = 8'h0; req_i = 1'b0; we_i = 1'b0;
    @(posedge clk);
    #1;
    check("midrun reset data_o", data_o, 32'h0);
    check("midrun reset int_flag_o", {24'h0, int_flag_o}, 32'h0);
    $display("mid-run reset: data_o=%h int_flag_o=%0d", data_o, int_flag_o);
    @(negedge clk);
    rst = 1'b0;
    vecs.delete();
    rd(0, EN, 32'h0, 0);
    rd(0, PEND, 32'h0, 0);
    rd(0, STAT, 32'h0, 0);
    idle(0, 0);
    foreach (vecs[i]) run_vec(vecs[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
